// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler: fetches 4-word descriptors, then runs bias-fill
// followed by convolution for each layer, and pulses done at the end.
module cnn_layer_sequencer #(
    parameter int DATA_SZ  = 16,
    parameter int ADDR_SZ  = 16,
    parameter int LAYER_SZ = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [ADDR_SZ-1:0]  desc_base_i,
    input  logic [LAYER_SZ-1:0] num_layers_i,
    output logic                mem_rd_en_o,
    output logic [ADDR_SZ-1:0]  mem_rd_addr_o,
    input  logic [DATA_SZ-1:0]  mem_rd_data_i,
    output logic                bias_en_o,
    output logic [ADDR_SZ-1:0]  bias_addr_o,
    output logic [DATA_SZ-1:0]  num_biases_o,
    output logic [ADDR_SZ-1:0]  out_img_addr_o,
    output logic [DATA_SZ-1:0]  out_img_size_o,
    input  logic                bias_done_i,
    output logic                conv_start_o,
    input  logic                conv_done_i,
    output logic [LAYER_SZ-1:0] cur_layer_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BIAS,
        S_BGAP,
        S_CSTART,
        S_CONV,
        S_NEXT,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_SZ-1:0]  base_q, base_d;
    logic [LAYER_SZ-1:0] num_q, num_d;
    logic [LAYER_SZ-1:0] layer_q, layer_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic [ADDR_SZ-1:0]  bias_addr_q, bias_addr_d;
    logic [DATA_SZ-1:0]  nbias_q, nbias_d;
    logic [ADDR_SZ-1:0]  img_addr_q, img_addr_d;
    logic [DATA_SZ-1:0]  img_size_q, img_size_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            layer_q     <= '0;
            wcnt_q      <= '0;
            bias_addr_q <= '0;
            nbias_q     <= '0;
            img_addr_q  <= '0;
            img_size_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            layer_q     <= layer_d;
            wcnt_q      <= wcnt_d;
            bias_addr_q <= bias_addr_d;
            nbias_q     <= nbias_d;
            img_addr_q  <= img_addr_d;
            img_size_q  <= img_size_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        num_d         = num_q;
        layer_d       = layer_q;
        wcnt_d        = wcnt_q;
        bias_addr_d   = bias_addr_q;
        nbias_d       = nbias_q;
        img_addr_d    = img_addr_q;
        img_size_d    = img_size_q;
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;
        bias_en_o     = 1'b0;
        conv_start_o  = 1'b0;
        done_o        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d  = desc_base_i;
                    num_d   = num_layers_i;
                    layer_d = '0;
                    wcnt_d  = '0;
                    // An empty run still passes through NEXT so done lands 2 cycles after start
                    state_d = (num_layers_i == '0) ? S_NEXT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (wcnt_q != 3'd4) begin
                    mem_rd_en_o   = 1'b1;
                    mem_rd_addr_o = base_q
                                  + (ADDR_SZ'(layer_q) << 2)
                                  + ADDR_SZ'(wcnt_q);
                end
                unique case (wcnt_q)
                    3'd1:    bias_addr_d = ADDR_SZ'(mem_rd_data_i);
                    3'd2:    nbias_d     = mem_rd_data_i;
                    3'd3:    img_addr_d  = ADDR_SZ'(mem_rd_data_i);
                    3'd4:    img_size_d  = mem_rd_data_i;
                    default: ;
                endcase
                if (wcnt_q == 3'd4) begin
                    wcnt_d  = '0;
                    state_d = S_BIAS;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            S_BIAS: begin
                bias_en_o = 1'b1;
                if (bias_done_i) state_d = S_BGAP;
            end
            // One cycle with enable low lets the bias engine re-arm
            S_BGAP:   state_d = S_CSTART;
            S_CSTART: begin
                conv_start_o = 1'b1;
                state_d      = S_CONV;
            end
            S_CONV: begin
                if (conv_done_i) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (num_q == '0 || layer_q + LAYER_SZ'(1) == num_q) begin
                    state_d = S_FIN;
                end else begin
                    layer_d = layer_q + LAYER_SZ'(1);
                    state_d = S_FETCH;
                end
            end
            S_FIN: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bias_addr_o    = bias_addr_q;
    assign num_biases_o   = nbias_q;
    assign out_img_addr_o = img_addr_q;
    assign out_img_size_o = img_size_q;
    assign cur_layer_o    = layer_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: RAM and engine models, transaction
// scoreboard, table-driven runs and hand-built corner sequences.
module tb_cnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] desc_base;
    logic [7:0]  num_layers;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        bias_en;
    logic [15:0] bias_addr;
    logic [15:0] num_biases;
    logic [15:0] out_img_addr;
    logic [15:0] out_img_size;
    logic        bias_done;
    logic        conv_start;
    logic        conv_done;
    logic [7:0]  cur_layer;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    cnn_layer_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .desc_base_i   (desc_base),
        .num_layers_i  (num_layers),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data),
        .bias_en_o     (bias_en),
        .bias_addr_o   (bias_addr),
        .num_biases_o  (num_biases),
        .out_img_addr_o(out_img_addr),
        .out_img_size_o(out_img_size),
        .bias_done_i   (bias_done),
        .conv_start_o  (conv_start),
        .conv_done_i   (conv_done),
        .cur_layer_o   (cur_layer),
        .busy_o        (busy),
        .done_o        (done)
    );

    logic [15:0] ram [65536];
    int checks = 0;
    int failures = 0;

    // bench-side drive requests, consumed once by step()
    bit          m_start, m_bias, m_conv, m_reset;
    logic [15:0] m_base;
    logic [7:0]  m_num;
    bit          auto_en;
    int          bmax, cmax;
    bit          b_arm, b_auto, c_busy, c_auto;
    int          b_cnt, c_cnt;
    logic [15:0] pend;

    // scoreboard
    logic [15:0] rd_q[$];
    logic [63:0] cfg_q[$];
    logic [7:0]  lay_q[$];
    int cs_cnt, done_cnt, mutex_err, stab_err, cyc;
    bit hold;
    logic [63:0] snap;
    int t_start, t_rd0, t_rdlast, t_bias0, t_bdone, t_cs0, t_cdone, t_done;

    typedef struct {
        logic [15:0] base;
        int          n;
        int          bm;
        int          cm;
        int          exp_reads;
        int          exp_cs;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] cfg_now();
        return {bias_addr, num_biases, out_img_addr, out_img_size};
    endfunction

    function automatic logic [127:0] outs_now();
        return {mem_rd_en, mem_rd_addr, bias_en, cfg_now(),
                conv_start, cur_layer, busy, done};
    endfunction

    task automatic clear_mon();
        rd_q.delete();
        cfg_q.delete();
        lay_q.delete();
        cs_cnt = 0; done_cnt = 0; mutex_err = 0; stab_err = 0;
        hold = 0;
        t_start = -1; t_rd0 = -1; t_rdlast = -1; t_bias0 = -1;
        t_bdone = -1; t_cs0 = -1; t_cdone = -1; t_done = -1;
    endtask

    // one cycle: observe outputs, then drive inputs for this cycle
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_rd_en) begin
            rd_q.push_back(mem_rd_addr);
            if (t_rd0 < 0) t_rd0 = cyc;
            t_rdlast = cyc;
        end
        if (bias_en && t_bias0 < 0) t_bias0 = cyc;
        if (bias_en && conv_start) mutex_err++;
        if (conv_start) begin
            cs_cnt++;
            cfg_q.push_back(cfg_now());
            lay_q.push_back(cur_layer);
            if (t_cs0 < 0) t_cs0 = cyc;
        end
        if (done) begin
            done_cnt++;
            if (t_done < 0) t_done = cyc;
        end
        if (mem_rd_en || done || !busy) hold = 0;
        else if (bias_en && !hold) begin
            hold = 1;
            snap = cfg_now();
        end else if (hold && cfg_now() !== snap) stab_err++;

        mem_rd_data = pend;
        pend = mem_rd_en ? ram[mem_rd_addr] : 16'hDEAD;

        if (reset || !auto_en) begin
            b_auto = 0; b_arm = 1; c_auto = 0; c_busy = 0;
            b_cnt = $urandom_range(bmax - 1, 0);
        end else begin
            b_auto = 0;
            if (!bias_en) begin
                b_arm = 1;
                b_cnt = $urandom_range(bmax - 1, 0);
            end else if (b_arm) begin
                if (b_cnt == 0) begin
                    b_auto = 1;
                    b_arm = 0;
                end else b_cnt--;
            end
            c_auto = 0;
            if (c_busy) begin
                if (c_cnt == 0) begin
                    c_auto = 1;
                    c_busy = 0;
                end else c_cnt--;
            end
            if (conv_start) begin
                c_busy = 1;
                c_cnt = $urandom_range(cmax - 1, 0);
            end
        end

        bias_done  = b_auto | m_bias;
        conv_done  = c_auto | m_conv;
        start      = m_start;
        desc_base  = m_base;
        num_layers = m_num;
        reset      = m_reset;
        if (start && t_start < 0) t_start = cyc;
        if (bias_done && t_bdone < 0) t_bdone = cyc;
        if (conv_done) t_cdone = cyc;
        m_start = 0; m_bias = 0; m_conv = 0; m_reset = 0;
    endtask

    task automatic verify(logic [15:0] base, int n);
        int bad;
        logic [15:0] a;
        logic [63:0] e;
        chk("read_count", rd_q.size(), 4 * n);
        bad = 0;
        foreach (rd_q[i]) begin
            a = base + 16'(4 * (i / 4) + (i % 4));
            if (rd_q[i] !== a) bad++;
        end
        chk("read_addr_seq", bad, 0);
        chk("conv_start_count", cs_cnt, n);
        bad = 0;
        foreach (cfg_q[l]) begin
            a = base + 16'(4 * l);
            e = {ram[a], ram[16'(a + 1)], ram[16'(a + 2)], ram[16'(a + 3)]};
            if (cfg_q[l] !== e) bad++;
            if (lay_q[l] !== 8'(l)) bad++;
        end
        chk("cfg_and_layer", bad, 0);
        chk("done_count", done_cnt, 1);
        chk("mutex_errors", mutex_err, 0);
        chk("cfg_stability_errors", stab_err, 0);
        chk("busy_after_run", busy, 0);
    endtask

    task automatic run(logic [15:0] base, int n, int bm, int cm);
        int lim;
        auto_en = 1;
        bmax = bm;
        cmax = cm;
        clear_mon();
        m_base = base;
        m_num = 8'(n);
        m_start = 1;
        step();
        lim = n * 120 + 20;
        for (int i = 0; i < lim && done_cnt == 0; i++) step();
        if (done_cnt == 0) begin
            chk("run_timeout", 0, 1);
            m_reset = 1;
            step();
        end
        repeat (3) step();
        verify(base, n);
    endtask

    vec_t vecs[5];

    initial begin
        logic [15:0] rb;
        int rn;
        vecs[0] = '{16'h0100, 1,   1, 1, 4,    1,   16'h0100, 16'h0103};
        vecs[1] = '{16'hFFFC, 3,   4, 4, 12,   3,   16'hFFFC, 16'h0007};
        vecs[2] = '{16'h0000, 0,   1, 1, 0,    0,   16'h0000, 16'h0000};
        vecs[3] = '{16'hFFFF, 2,   8, 3, 8,    2,   16'hFFFF, 16'h0006};
        vecs[4] = '{16'h8000, 255, 1, 1, 1020, 255, 16'h8000, 16'h83FB};

        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        ram[16'h0100] = 16'h0200;
        ram[16'h0101] = 16'd3;
        ram[16'h0102] = 16'h0400;
        ram[16'h0103] = 16'd4;

        reset = 1; start = 0; desc_base = 0; num_layers = 0;
        bias_done = 0; conv_done = 0; mem_rd_data = 0;
        m_base = 0; m_num = 0; auto_en = 0; bmax = 1; cmax = 1;
        pend = 16'hDEAD; cyc = 0;
        clear_mon();
        repeat (3) begin
            m_reset = 1;
            step();
        end
        step();
        chk("reset_outputs", outs_now(), 0);

        // single layer with latency checks
        run(16'h0100, 1, 5, 5);
        chk("lat_start_to_rd", t_rd0 - t_start, 1);
        chk("lat_capture_to_bias", t_bias0 - t_rdlast, 2);
        chk("lat_bdone_to_cstart", t_cs0 - t_bdone, 2);
        chk("lat_cdone_to_done", t_done - t_cdone, 2);
        chk("cfg_layer1", cfg_now(), {16'h0200, 16'd3, 16'h0400, 16'd4});

        foreach (vecs[v]) begin
            run(vecs[v].base, vecs[v].n, vecs[v].bm, vecs[v].cm);
            chk($sformatf("vec%0d_reads", v), rd_q.size(), vecs[v].exp_reads);
            chk($sformatf("vec%0d_cstarts", v), cs_cnt, vecs[v].exp_cs);
            if (vecs[v].exp_reads > 0) begin
                chk($sformatf("vec%0d_first", v), rd_q[0], vecs[v].exp_first);
                chk($sformatf("vec%0d_last", v), rd_q[$], vecs[v].exp_last);
            end
        end

        run(16'h0040, 0, 1, 1);
        chk("zero_layers_done_lat", t_done - t_start, 2);

        // spurious conv_done in BIAS, start in CONV, both dones together
        auto_en = 0;
        clear_mon();
        m_base = 16'h0100;
        m_num = 8'd1;
        m_start = 1;
        step();
        for (int i = 0; i < 10 && !bias_en; i++) step();
        chk("hs_reach_bias", bias_en, 1);
        m_conv = 1;
        step();
        step();
        chk("hs_spur_conv_bias_en", bias_en, 1);
        chk("hs_spur_conv_no_cs", conv_start, 0);
        m_bias = 1;
        step();
        step();
        chk("hs_gap_bias_low", {bias_en, conv_start}, 2'b00);
        step();
        chk("hs_cstart", conv_start, 1);
        m_start = 1;
        m_num = 8'd5;
        step();
        step();
        chk("hs_start_ignored", {busy, mem_rd_en, bias_en, cur_layer}, 11'h400);
        m_conv = 1;
        m_bias = 1;
        step();
        for (int i = 0; i < 6 && done_cnt == 0; i++) step();
        repeat (2) step();
        chk("hs_done_count", done_cnt, 1);
        chk("hs_reads", rd_q.size(), 4);
        chk("hs_cstarts", cs_cnt, 1);

        // reset during CONV with conv_done pending
        clear_mon();
        auto_en = 1;
        bmax = 3;
        cmax = 40;
        m_base = 16'h2000;
        m_num = 8'd2;
        m_start = 1;
        step();
        for (int i = 0; i < 60 && cs_cnt == 0; i++) step();
        chk("rst_reach_conv", cs_cnt, 1);
        auto_en = 0;
        m_conv = 1;
        m_reset = 1;
        step();
        step();
        chk("rst_outputs_zero", outs_now(), 0);
        step();
        chk("rst_no_glitch", {bias_en, conv_start, busy}, 3'b000);
        run(16'h2000, 2, 4, 4);

        // randomized runs with long engine delays
        for (int r = 0; r < 4; r++) begin
            rb = 16'($urandom);
            rn = (r < 2) ? 8 : int'($urandom_range(12, 1));
            run(rb, rn, 50, 50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
